// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control unit.
// Contents: opcode values, ALUOp encodings, per-stage control bundle types and the
// all-zero bubble constants that every stage register loads on a bubble or reset.
package ctrl_pipe_pkg;

    localparam int unsigned CTRL_OPCODE_W = 6;
    localparam int unsigned CTRL_ALUOP_W  = 2;
    localparam int unsigned CTRL_REG_W    = 5;

    localparam logic [CTRL_OPCODE_W-1:0] R_FORMAT = 6'd0;
    localparam logic [CTRL_OPCODE_W-1:0] ADDIU    = 6'd9;
    localparam logic [CTRL_OPCODE_W-1:0] LW       = 6'd35;
    localparam logic [CTRL_OPCODE_W-1:0] SW       = 6'd43;
    localparam logic [CTRL_OPCODE_W-1:0] BEQ      = 6'd4;
    localparam logic [CTRL_OPCODE_W-1:0] BNE      = 6'd5;
    localparam logic [CTRL_OPCODE_W-1:0] J        = 6'd2;

    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic                    reg_dst;
        logic                    alu_src;
        logic [CTRL_ALUOP_W-1:0] alu_op;
    } ctrl_ex_t;

    typedef struct packed {
        logic read;
        logic write;
        logic branch;
        logic branch_ne;
        logic jump;
    } ctrl_mem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } ctrl_wb_t;

    localparam ctrl_ex_t  EX_BUBBLE  = '0;
    localparam ctrl_mem_t MEM_BUBBLE = '0;
    localparam ctrl_wb_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder for the pipeline control unit.
// Ports:
//   opcode_i   - ID-stage opcode
//   ex_o       - EX control bundle (RegDst, ALUSrc, ALUOp)
//   mem_o      - MEM control bundle (MemRead, MemWrite, Branch, BranchNe, Jump)
//   wb_o       - WB control bundle (RegWrite, MemtoReg)
//   ext_sel_o  - 1 = sign-extend immediate, 0 = zero-extend
//   illegal_o  - opcode is not one of the defined instructions
// Undefined opcodes decode to an all-zero bundle so nothing unknown ever leaves the block.
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned OPCODE_W = CTRL_OPCODE_W
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_ex_t            ex_o,
    output ctrl_mem_t           mem_o,
    output ctrl_wb_t            wb_o,
    output logic                ext_sel_o,
    output logic                illegal_o
);

    always_comb begin
        ex_o      = EX_BUBBLE;
        mem_o     = MEM_BUBBLE;
        wb_o      = WB_BUBBLE;
        ext_sel_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            R_FORMAT: begin
                ex_o.reg_dst    = 1'b1;
                ex_o.alu_op     = ALUOP_FUNCT;
                wb_o.reg_write  = 1'b1;
            end
            ADDIU: begin
                ex_o.alu_src    = 1'b1;
                ex_o.alu_op     = ALUOP_ADD;
                wb_o.reg_write  = 1'b1;
            end
            LW: begin
                ex_o.alu_src    = 1'b1;
                ex_o.alu_op     = ALUOP_ADD;
                mem_o.read      = 1'b1;
                wb_o.reg_write  = 1'b1;
                wb_o.mem_to_reg = 1'b1;
                ext_sel_o       = 1'b1;
            end
            SW: begin
                ex_o.alu_src    = 1'b1;
                ex_o.alu_op     = ALUOP_ADD;
                mem_o.write     = 1'b1;
                ext_sel_o       = 1'b1;
            end
            BEQ: begin
                ex_o.alu_op     = ALUOP_SUB;
                mem_o.branch    = 1'b1;
                ext_sel_o       = 1'b1;
            end
            BNE: begin
                ex_o.alu_op     = ALUOP_SUB;
                mem_o.branch    = 1'b1;
                mem_o.branch_ne = 1'b1;
                ext_sel_o       = 1'b1;
            end
            J: begin
                mem_o.jump      = 1'b1;
            end
            default: begin
                illegal_o       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipeline_unit.sv
// Main control for the 5-stage MIPS core. Decodes the ID-stage opcode and carries the
// control bundle through the ID/EX, EX/MEM and MEM/WB stage registers.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   id_valid, id_opcode   - ID-stage instruction
//   id_rs, id_rt          - ID source specifiers (load-use hazard compare only)
//   stall, flush          - external stall (ID/EX bubble), branch/jump flush (ID/EX, EX/MEM bubble)
//   id_extend_sel         - comb immediate extension select
//   hazard_stall          - comb load-use stall request to PC/IFID
//   ex_*, mem_*, wb_*     - per-stage control outputs; ex_illegal flags an undefined opcode in EX
// Configuration: define CTRL_HAZARD_DET_EN to enable the internal load-use hazard detector;
// otherwise hazard_stall is tied low and id_rs/id_rt are ignored.
module ctrl_pipeline_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned OPCODE_W   = CTRL_OPCODE_W,
    parameter int unsigned ALUOP_W    = CTRL_ALUOP_W,
    parameter int unsigned REG_ADDR_W = CTRL_REG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  id_extend_sel,
    output logic                  hazard_stall,
    output logic                  ex_reg_dst,
    output logic                  ex_alu_src,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_branch,
    output logic                  mem_branch_ne,
    output logic                  mem_jump,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  ex_illegal
);

    ctrl_ex_t  dec_ex;
    ctrl_mem_t dec_mem;
    ctrl_wb_t  dec_wb;
    logic      dec_illegal;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode_i  (id_opcode),
        .ex_o      (dec_ex),
        .mem_o     (dec_mem),
        .wb_o      (dec_wb),
        .ext_sel_o (id_extend_sel),
        .illegal_o (dec_illegal)
    );

    ctrl_ex_t  idex_ex_q,   idex_ex_d;
    ctrl_mem_t idex_mem_q,  idex_mem_d;
    ctrl_wb_t  idex_wb_q,   idex_wb_d;
    logic      idex_ill_q,  idex_ill_d;
    ctrl_mem_t exmem_mem_q, exmem_mem_d;
    ctrl_wb_t  exmem_wb_q,  exmem_wb_d;
    ctrl_wb_t  memwb_wb_q,  memwb_wb_d;
    logic      idex_bubble;

`ifdef CTRL_HAZARD_DET_EN
    logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
    logic                  idex_ld_q, idex_ld_d;

    // A load in EX whose destination feeds the ID instruction; $zero never creates a hazard.
    assign hazard_stall = idex_ld_q & id_valid & (idex_rt_q != '0) &
                          ((idex_rt_q == id_rs) | (idex_rt_q == id_rt));
`else
    logic unused_ids;
    assign unused_ids   = ^{id_rs, id_rt};
    assign hazard_stall = 1'b0;
`endif

    assign idex_bubble = flush | stall | hazard_stall | ~id_valid;

    always_comb begin
        idex_ex_d   = dec_ex;
        idex_mem_d  = dec_mem;
        idex_wb_d   = dec_wb;
        idex_ill_d  = dec_illegal;
`ifdef CTRL_HAZARD_DET_EN
        idex_rt_d   = id_rt;
        idex_ld_d   = dec_mem.read;
`endif
        if (idex_bubble) begin
            idex_ex_d  = EX_BUBBLE;
            idex_mem_d = MEM_BUBBLE;
            idex_wb_d  = WB_BUBBLE;
            idex_ill_d = 1'b0;
`ifdef CTRL_HAZARD_DET_EN
            idex_rt_d  = '0;
            idex_ld_d  = 1'b0;
`endif
        end
        // EX/MEM only ever bubbles on flush; MEM/WB always advances so a branch retires.
        exmem_mem_d = flush ? MEM_BUBBLE : idex_mem_q;
        exmem_wb_d  = flush ? WB_BUBBLE  : idex_wb_q;
        memwb_wb_d  = exmem_wb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex_q   <= EX_BUBBLE;
            idex_mem_q  <= MEM_BUBBLE;
            idex_wb_q   <= WB_BUBBLE;
            idex_ill_q  <= 1'b0;
            exmem_mem_q <= MEM_BUBBLE;
            exmem_wb_q  <= WB_BUBBLE;
            memwb_wb_q  <= WB_BUBBLE;
`ifdef CTRL_HAZARD_DET_EN
            idex_rt_q   <= '0;
            idex_ld_q   <= 1'b0;
`endif
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            idex_ill_q  <= idex_ill_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_wb_q  <= exmem_wb_d;
            memwb_wb_q  <= memwb_wb_d;
`ifdef CTRL_HAZARD_DET_EN
            idex_rt_q   <= idex_rt_d;
            idex_ld_q   <= idex_ld_d;
`endif
        end
    end

    assign ex_reg_dst    = idex_ex_q.reg_dst;
    assign ex_alu_src    = idex_ex_q.alu_src;
    assign ex_alu_op     = idex_ex_q.alu_op;
    assign ex_illegal    = idex_ill_q;
    assign mem_read      = exmem_mem_q.read;
    assign mem_write     = exmem_mem_q.write;
    assign mem_branch    = exmem_mem_q.branch;
    assign mem_branch_ne = exmem_mem_q.branch_ne;
    assign mem_jump      = exmem_mem_q.jump;
    assign wb_reg_write  = memwb_wb_q.reg_write;
    assign wb_mem_to_reg = memwb_wb_q.mem_to_reg;

endmodule

// File: tb/tb_ctrl_pipeline_unit.sv
// Self-checking bench for ctrl_pipeline_unit: directed scenarios plus a randomized run,
// all checked against a table-driven reference model of the control pipeline.
module tb_ctrl_pipeline_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       id_extend_sel, hazard_stall;
    logic       ex_reg_dst, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       mem_read, mem_write, mem_branch, mem_branch_ne, mem_jump;
    logic       wb_reg_write, wb_mem_to_reg, ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipeline_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .stall         (stall),
        .flush         (flush),
        .id_extend_sel (id_extend_sel),
        .hazard_stall  (hazard_stall),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_branch    (mem_branch),
        .mem_branch_ne (mem_branch_ne),
        .mem_jump      (mem_jump),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .ex_illegal    (ex_illegal)
    );

    // Observed registered outputs: {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Br, BrNe, Jump,
    // RegWrite, MemtoReg, illegal}
    logic [11:0] obs;
    assign obs = {ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write, mem_branch,
                  mem_branch_ne, mem_jump, wb_reg_write, wb_mem_to_reg, ex_illegal};

    // Control word straight from the decode table, fields in table order:
    // [12]RegDst [11]ALUSrc [10]MemtoReg [9]RegWrite [8]MemRead [7]MemWrite [6]Br [5]BrNe
    // [4]Jump [3:2]ALUOp [1]Ext [0]illegal
    function automatic logic [12:0] ref_decode(input logic [5:0] op);
        case (op)
            6'd0:    return {12'b1001_0000_0100, 1'b0};
            6'd9:    return {12'b0101_0000_0000, 1'b0};
            6'd35:   return {12'b0111_1000_0001, 1'b0};
            6'd43:   return {12'b0100_0100_0001, 1'b0};
            6'd4:    return {12'b0000_0010_0011, 1'b0};
            6'd5:    return {12'b0000_0011_0011, 1'b0};
            6'd2:    return {12'b0000_0000_1000, 1'b0};
            default: return {12'b0000_0000_0000, 1'b1};
        endcase
    endfunction

    // Model: the control word each stage currently holds, plus rt of the EX instruction.
    logic [12:0] m_ex = '0, m_mem = '0, m_wb = '0;
    logic [4:0]  m_rt = '0;
    logic [11:0] exp_obs;
    logic        exp_hz, exp_ext;

    always_comb begin
        exp_obs = {m_ex[12], m_ex[11], m_ex[3:2], m_mem[8:4], m_wb[9], m_wb[10], m_ex[0]};
    end

    function automatic logic model_hazard();
`ifdef CTRL_HAZARD_DET_EN
        return m_ex[8] && id_valid && (m_rt != 0) && (m_rt == id_rs || m_rt == id_rt);
`else
        return 1'b0;
`endif
    endfunction

    // Apply ID inputs and let combinational outputs settle.
    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic st, input logic fl);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        stall     = st;
        flush     = fl;
        #1;
        exp_hz  = model_hazard();
        exp_ext = ref_decode(op)[1];
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        logic [12:0] w;
        logic        bub;
        @(posedge clk);
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_rt = '0;
        end else begin
            w   = ref_decode(id_opcode);
            bub = flush || stall || exp_hz || !id_valid;
            m_wb  = m_mem;
            m_mem = flush ? 13'd0 : m_ex;
            m_ex  = bub ? 13'd0 : w;
            m_rt  = bub ? 5'd0 : id_rt;
        end
        #1;
    endtask

    task automatic test_reset();
        // Held in reset from time 0.
        @(posedge clk); #1;
        checks++;
        if (obs !== 12'd0) begin
            $display("FAIL reset_initial obs=%b exp=%b", obs, 12'd0); errors++;
        end
        #2 rst_n = 1'b1;
        drive(1, 6'd35, 5'd1, 5'd8, 0, 0); tick();
        drive(1, 6'd35, 5'd2, 5'd9, 0, 0); tick();
        drive(1, 6'd0, 5'd3, 5'd4, 0, 0);  tick();
        checks++;
        if (obs !== exp_obs) begin
            $display("FAIL reset_preflight obs=%b exp=%b", obs, exp_obs); errors++;
        end
        // Asynchronous assertion mid-cycle with loads in flight.
        rst_n = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_rt = '0;
        #1;
        checks++;
        if (obs !== 12'd0) begin
            $display("FAIL reset_async obs=%b exp=%b", obs, 12'd0); errors++;
        end
        tick();
        checks++;
        if (obs !== 12'd0) begin
            $display("FAIL reset_hold obs=%b exp=%b", obs, 12'd0); errors++;
        end
        #2 rst_n = 1'b1;
        drive(0, 6'd35, 5'd0, 5'd0, 0, 0); tick();
        checks++;
        if (obs !== 12'd0) begin
            $display("FAIL reset_release obs=%b exp=%b", obs, 12'd0); errors++;
        end
        drive(1, 6'd9, 5'd1, 5'd2, 0, 0); tick();
        checks++;
        if (obs !== exp_obs) begin
            $display("FAIL reset_first_valid obs=%b exp=%b", obs, exp_obs); errors++;
        end
    endtask

    task automatic test_stream();
        logic [5:0] ops [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
        logic [4:0] rss [5] = '{5'd1, 5'd3, 5'd9, 5'd11, 5'd0};
        logic [4:0] rts [5] = '{5'd2, 5'd8, 5'd10, 5'd12, 5'd0};
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(1, ops[i], rss[i], rts[i], 0, 0);
            else       drive(0, 6'd0, 5'd0, 5'd0, 0, 0);
            checks++;
            if (id_extend_sel !== exp_ext) begin
                $display("FAIL stream_ext i=%0d got=%b exp=%b", i, id_extend_sel, exp_ext);
                errors++;
            end
            tick();
            checks++;
            if (obs !== exp_obs) begin
                $display("FAIL stream i=%0d obs=%b exp=%b", i, obs, exp_obs); errors++;
            end
        end
    endtask

    task automatic test_hazard();
        logic want;
`ifdef CTRL_HAZARD_DET_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        drive(1, 6'd35, 5'd1, 5'd8, 0, 0); tick();
        drive(1, 6'd0, 5'd8, 5'd1, 0, 0);
        checks++;
        if (hazard_stall !== want) begin
            $display("FAIL hazard_detect got=%b exp=%b", hazard_stall, want); errors++;
        end
        tick();
        checks++;
        if (obs !== exp_obs) begin
            $display("FAIL hazard_bubble obs=%b exp=%b", obs, exp_obs); errors++;
        end
        // ID held the ADD while stalled; present it again.
        if (want) begin
            drive(1, 6'd0, 5'd8, 5'd1, 0, 0);
            checks++;
            if (hazard_stall !== 1'b0) begin
                $display("FAIL hazard_one_cycle got=%b exp=0", hazard_stall); errors++;
            end
            tick();
        end
        checks++;
        if (ex_reg_dst !== 1'b1 || ex_alu_op !== 2'b10) begin
            $display("FAIL hazard_add_in_ex obs=%b exp=%b", obs, exp_obs); errors++;
        end
    endtask

    task automatic test_flush();
        drive(1, 6'd4, 5'd1, 5'd2, 0, 0); tick();
        drive(1, 6'd0, 5'd3, 5'd4, 0, 0); tick();
        checks++;
        if (mem_branch !== 1'b1) begin
            $display("FAIL flush_beq_in_mem got=%b exp=1", mem_branch); errors++;
        end
        drive(1, 6'd43, 5'd5, 5'd6, 1, 1); tick();
        checks++;
        if (obs !== 12'd0) begin
            $display("FAIL flush_all_zero obs=%b exp=%b", obs, 12'd0); errors++;
        end
        checks++;
        if (obs !== exp_obs) begin
            $display("FAIL flush_model obs=%b exp=%b", obs, exp_obs); errors++;
        end
        drive(0, 6'd0, 5'd0, 5'd0, 0, 0); tick();
    endtask

    task automatic test_illegal();
        drive(1, 6'd63, 5'd1, 5'd2, 0, 0);
        checks++;
        if (id_extend_sel !== 1'b0) begin
            $display("FAIL illegal_ext got=%b exp=0", id_extend_sel); errors++;
        end
        tick();
        checks++;
        if (obs !== 12'b0000_0000_0001) begin
            $display("FAIL illegal_flag obs=%b exp=%b", obs, 12'b1); errors++;
        end
        drive(0, 6'd0, 5'd0, 5'd0, 0, 0); tick();
        checks++;
        if (ex_illegal !== 1'b0) begin
            $display("FAIL illegal_one_cycle got=%b exp=0", ex_illegal); errors++;
        end
    endtask

    task automatic test_drain();
        drive(1, 6'd35, 5'd1, 5'd0, 0, 0); tick();
        drive(1, 6'd0, 5'd0, 5'd0, 0, 0);
        checks++;
        if (hazard_stall !== 1'b0) begin
            $display("FAIL zero_reg_no_hazard got=%b exp=0", hazard_stall); errors++;
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 6'd35, 5'd1, 5'd1, 0, 0); tick();
        end
        checks++;
        if (obs !== 12'd0) begin
            $display("FAIL drain obs=%b exp=%b", obs, 12'd0); errors++;
        end
    endtask

    task automatic test_random();
        logic [5:0] legal [7] = '{6'd0, 6'd9, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
        logic [5:0] op;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom % 5 == 0) ? 6'($urandom) : legal[$urandom % 7];
            drive(($urandom % 4) != 0, op, 5'($urandom % 4), 5'($urandom % 4),
                  ($urandom % 8) == 0, ($urandom % 10) == 0);
            checks++;
            if (hazard_stall !== exp_hz || id_extend_sel !== exp_ext) begin
                $display("FAIL rand_comb i=%0d hz=%b/%b ext=%b/%b", i, hazard_stall, exp_hz,
                         id_extend_sel, exp_ext);
                errors++;
            end
            tick();
            checks++;
            if (obs !== exp_obs) begin
                $display("FAIL rand_regs i=%0d obs=%b exp=%b", i, obs, exp_obs); errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hazard();
        test_flush();
        test_illegal();
        test_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
